// File: rtl/sync_fifo_param_pkg.sv
// fifo_pkg: shared sizing helpers and default geometry for sync_fifo_param.
//   DEF_WIDTH / DEF_DEPTH : default word width and entry count
//   clog2(v)              : ceil(log2(v)), 0 for v<=1
//   addr_w(d)             : pointer width for a d-entry array (at least 1)
//   cnt_w(d)              : occupancy width able to hold 0..d
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int addr_w(input int d);
    return d < 2 ? 1 : clog2(d);
  endfunction
  function automatic int cnt_w(input int d);
    return clog2(d) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake/data bundle between a FIFO user and sync_fifo_param.
//   master : the user side; drives wn, rn, DATAIN and observes data, flags and errors
//   slave  : the FIFO side; the reverse
interface sync_fifo_param_if import fifo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic                      wn;
  logic                      rn;
  logic [WIDTH-1:0]          DATAIN;
  logic [WIDTH-1:0]          DATAOUT;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic [cnt_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      underflow;
  modport master (
    output wn, rn, DATAIN,
    input  DATAOUT, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wn, rn, DATAIN,
    output DATAOUT, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// fifo_mem: DEPTH x WIDTH register array, synchronous write, asynchronous read.
//   clk                : write clock
//   we, waddr, wdata   : write port, captured at posedge when we=1
//   raddr, rdata       : combinational read port
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and registered overflow/underflow pulses.
//   clock : rising-edge clock
//   reset : synchronous, active-low; clears pointers, count, DATAOUT and error pulses
//   bus   : slave side of sync_fifo_param_if (wn/rn/DATAIN in; DATAOUT, flags, count,
//           overflow, underflow out)
// Build option FIFO_FWFT_EN: first-word-fall-through; DATAOUT shows the head entry
// whenever the FIFO is non-empty and rn pops it. Undefined: 1-cycle registered read.
module sync_fifo_param import fifo_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic              clock,
  input logic              reset,
  sync_fifo_param_if.slave bus
);
  localparam int AW = addr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n, raddr;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] rdata, dout;
  logic             rd_ok, wr_ok, ovf, unf;
  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign rd_ok = bus.rn && !bus.empty;
  assign wr_ok = bus.wn && (!bus.full || rd_ok);
  always_comb begin
    rd_ptr_n = rd_ok ? rd_ptr + AW'(1) : rd_ptr;
    cnt_n    = (wr_ok && !rd_ok) ? cnt + CW'(1) : (rd_ok && !wr_ok) ? cnt - CW'(1) : cnt;
  end
`ifdef FIFO_FWFT_EN
  // Prefetch the head as it will be after this edge.
  assign raddr = rd_ptr_n;
`else
  assign raddr = rd_ptr;
`endif
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clock),
    .we    (wr_ok && reset),
    .waddr (wr_ptr),
    .wdata (bus.DATAIN),
    .raddr (raddr),
    .rdata (rdata)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_ptr_n;
      cnt    <= cnt_n;
      ovf    <= bus.wn && !wr_ok;
      unf    <= bus.rn && !rd_ok;
`ifdef FIFO_FWFT_EN
      // If the next head is the slot being written now it is not in the array yet,
      // so forward DATAIN; an empty FIFO keeps the last value.
      if (cnt_n != '0) dout <= (wr_ok && wr_ptr == rd_ptr_n) ? bus.DATAIN : rdata;
`else
      if (rd_ok) dout <= rdata;
`endif
    end
  end
  assign bus.DATAOUT      = dout;
  assign bus.count        = cnt;
  assign bus.empty        = cnt == '0;
  assign bus.full         = cnt == CW'(DEPTH);
  assign bus.almost_full  = cnt >= CW'(AF_LEVEL);
  assign bus.almost_empty = cnt <= CW'(AE_LEVEL);
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=8).
// Works with or without FIFO_FWFT_EN; the xfer task reads DATAOUT where each mode presents it.
module tb_sync_fifo_param;
  logic clock, reset;
  int checks, errors;
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) bus ();
  sync_fifo_param #(.WIDTH(8), .DEPTH(8)) dut (.clock(clock), .reset(reset), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    bus.wn = w;
    bus.rn = r;
    bus.DATAIN = d;
    @(posedge clock);
    #1;
    bus.wn = 1'b0;
    bus.rn = 1'b0;
  endtask
  // Read one word (optionally with a simultaneous write) and return the popped value.
  task automatic xfer(input logic w, input logic [7:0] d, output logic [7:0] v);
`ifdef FIFO_FWFT_EN
    v = bus.DATAOUT;
    cyc(w, 1'b1, d);
`else
    cyc(w, 1'b1, d);
    v = bus.DATAOUT;
`endif
  endtask
  task automatic test_reset;
    reset = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    checks += 6;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b expected 10", bus.empty, bus.full); end
    if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost: got %b%b expected 10", bus.almost_empty, bus.almost_full); end
    if (bus.DATAOUT !== 8'd0) begin errors++; $display("FAIL reset_dataout: got %0d expected 0", bus.DATAOUT); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", bus.underflow); end
    reset = 1'b1;
  endtask
  task automatic test_order;
    logic [7:0] vals [7] = '{100, 150, 200, 40, 70, 65, 15};
    logic [7:0] v;
    foreach (vals[i]) cyc(1, 0, vals[i]);
    checks++;
    if (bus.count !== 4'd7) begin errors++; $display("FAIL order_count_full: got %0d expected 7", bus.count); end
    foreach (vals[i]) begin
      xfer(0, 0, v);
      checks += 2;
      if (v !== vals[i]) begin errors++; $display("FAIL order_data[%0d]: got %0d expected %0d", i, v, vals[i]); end
      if (bus.count !== 4'(6 - i)) begin errors++; $display("FAIL order_count[%0d]: got %0d expected %0d", i, bus.count, 6 - i); end
    end
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL order_empty: got %b expected 1", bus.empty); end
  endtask
  task automatic test_full;
    logic [7:0] v;
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 8'(i));
      checks += 2;
      if (bus.almost_full !== (i >= 7)) begin errors++; $display("FAIL full_af[%0d]: got %b expected %b", i, bus.almost_full, i >= 7); end
      if (bus.full !== (i == 8)) begin errors++; $display("FAIL full_full[%0d]: got %b expected %b", i, bus.full, i == 8); end
    end
    cyc(1, 0, 99);
    checks += 2;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL full_ovf_pulse: got %b expected 1", bus.overflow); end
    if (bus.count !== 4'd8) begin errors++; $display("FAIL full_ovf_count: got %0d expected 8", bus.count); end
    cyc(0, 0, 0);
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_clear: got %b expected 0", bus.overflow); end
    for (int i = 1; i <= 8; i++) begin
      xfer(0, 0, v);
      checks++;
      if (v !== 8'(i)) begin errors++; $display("FAIL full_data[%0d]: got %0d expected %0d", i, v, i); end
    end
  endtask
  task automatic test_underflow;
    logic [7:0] d0, v;
    d0 = bus.DATAOUT;
    cyc(0, 1, 0);
    checks += 3;
    if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse: got %b expected 1", bus.underflow); end
    if (bus.DATAOUT !== d0) begin errors++; $display("FAIL unf_dataout: got %0d expected %0d", bus.DATAOUT, d0); end
    if (bus.count !== 4'd0) begin errors++; $display("FAIL unf_count: got %0d expected 0", bus.count); end
    cyc(0, 0, 0);
    checks++;
    if (bus.underflow !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", bus.underflow); end
    cyc(1, 1, 33);
    checks += 2;
    if (bus.count !== 4'd1) begin errors++; $display("FAIL unf_wr_count: got %0d expected 1", bus.count); end
    if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_wr_pulse: got %b expected 1", bus.underflow); end
    xfer(0, 0, v);
    checks += 2;
    if (v !== 8'd33) begin errors++; $display("FAIL unf_wr_data: got %0d expected 33", v); end
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL unf_wr_empty: got %b expected 1", bus.empty); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] v;
    logic [7:0] exp [8] = '{3, 4, 5, 6, 7, 8, 9, 10};
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i));
    xfer(1, 9, v);
    checks += 4;
    if (v !== 8'd1) begin errors++; $display("FAIL b2b_full_data: got %0d expected 1", v); end
    if (bus.count !== 4'd8) begin errors++; $display("FAIL b2b_full_count: got %0d expected 8", bus.count); end
    if (bus.full !== 1'b1) begin errors++; $display("FAIL b2b_full_flag: got %b expected 1", bus.full); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_full_ovf: got %b expected 0", bus.overflow); end
    for (int i = 2; i <= 6; i++) xfer(0, 0, v);
    checks++;
    if (bus.count !== 4'd3) begin errors++; $display("FAIL b2b_mid_pre: got %0d expected 3", bus.count); end
    xfer(1, 10, v);
    checks += 2;
    if (v !== 8'd7) begin errors++; $display("FAIL b2b_mid_data: got %0d expected 7", v); end
    if (bus.count !== 4'd3) begin errors++; $display("FAIL b2b_mid_count: got %0d expected 3", bus.count); end
    for (int i = 5; i < 8; i++) begin
      xfer(0, 0, v);
      checks++;
      if (v !== exp[i]) begin errors++; $display("FAIL b2b_tail[%0d]: got %0d expected %0d", i, v, exp[i]); end
    end
  endtask
  task automatic test_wrap;
    logic [7:0] v;
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(r * 5 + i));
      for (int i = 1; i <= 5; i++) begin
        xfer(0, 0, v);
        checks += 2;
        if (v !== 8'(r * 5 + i)) begin errors++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", r * 5 + i, v, r * 5 + i); end
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL wrap_err[%0d]: got %b%b expected 00", r * 5 + i, bus.overflow, bus.underflow); end
      end
    end
  endtask
  task automatic test_reset_mid;
    logic [7:0] v;
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(50 + i));
    xfer(0, 0, v);
    cyc(1, 0, 60);
    checks++;
    if (bus.count !== 4'd5) begin errors++; $display("FAIL mid_pre_count: got %0d expected 5", bus.count); end
    reset = 1'b0;
    cyc(1, 1, 77);
    reset = 1'b1;
    checks += 3;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", bus.count); end
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", bus.empty); end
    if (bus.DATAOUT !== 8'd0) begin errors++; $display("FAIL mid_dataout: got %0d expected 0", bus.DATAOUT); end
    cyc(1, 0, 42);
`ifdef FIFO_FWFT_EN
    checks += 2;
    if (bus.DATAOUT !== 8'd42) begin errors++; $display("FAIL fwft_head: got %0d expected 42", bus.DATAOUT); end
    if (bus.empty !== 1'b0) begin errors++; $display("FAIL fwft_not_empty: got %b expected 0", bus.empty); end
`endif
    xfer(0, 0, v);
    checks += 2;
    if (v !== 8'd42) begin errors++; $display("FAIL mid_after_data: got %0d expected 42", v); end
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_after_empty: got %b expected 1", bus.empty); end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    bus.wn = 1'b0;
    bus.rn = 1'b0;
    bus.DATAIN = '0;
    test_reset;
    test_order;
    test_full;
    test_underflow;
    test_back_to_back;
    test_wrap;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
